// File: rtl/arm_pkg.sv
// Shared fetch-path types and constants.
// Widths, PC step, NOP encoding, fetch FSM states, IF/ID bundle.
package arm_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > freeze > load > clear.
// Ports: clk, rst (async active-low), flush, freeze, load, d in, q out.
module if_id_reg
  import arm_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   freeze,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q;
  if_id_t q_d;

  // Flush and freeze may both be high; flush must win.
  always_comb begin
    q_d = '0;
    priority case (1'b1)
      flush:   q_d = '0;
      freeze:  q_d = q_q;
      load:    q_d = d;
      default: q_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC mux, RUN/HALT FSM, delivered counter.
// Ports: clk, rst(n), freeze, branch_*, imem_*, id_*, halted, fetch_count.
module fetch_stage
  import arm_pkg::*;
#(
  parameter int MEM_BYTES = 72,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt;
  logic              in_range;
  logic              at_end;
  logic              load;
  if_id_t            ifid_d;
  if_id_t            ifid_q;

  assign pc_inc   = pc_q + PC_STEP;
  assign tgt      = {branch_addr[ADDR_W-1:2], 2'b00};
  assign in_range = (pc_q <= LAST_ADDR);
  assign at_end   = (pc_inc > LAST_ADDR);
  assign load     = !branch_taken && !freeze &&
                    (state_q == RUN) && in_range;

  // The last word is fetched without advancing, so the PC
  // never leaves the image while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (branch_taken) begin
      pc_d    = tgt;
      state_d = (tgt <= LAST_ADDR) ? RUN : HALT;
    end else if (!freeze && state_q == RUN) begin
      if (at_end) state_d = HALT;
      else        pc_d    = pc_inc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    ifid_d       = '0;
    ifid_d.pc    = pc_inc;
    ifid_d.inst  = imem_inst;
    ifid_d.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .rst    (rst),
    .flush  (branch_taken),
    .freeze (freeze),
    .load   (load),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign imem_addr   = pc_q;
  assign id_pc       = ifid_q.pc;
  assign id_inst     = ifid_q.inst;
  assign id_valid    = ifid_q.valid;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule
